// File: rtl/axi_audio_frame_bridge.sv
// AXI4-Lite slave that stages multichannel audio samples, queues them as frames in a FIFO,
// and releases one frame per audio_tick onto a parallel audio bus with status and a low-water irq.
module axi_audio_frame_bridge #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_CHANNELS       = 2,
  parameter int SAMPLE_WIDTH       = 24,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  input  logic                                   audio_tick,
  output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0]   audio_data,
  output logic                                   audio_valid,
  output logic                                   irq
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int SW = SAMPLE_WIDTH;
  localparam int FW = NUM_CHANNELS * SAMPLE_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  localparam logic [AW-1:0] A_CTRL   = AW'(0);
  localparam logic [AW-1:0] A_STATUS = AW'(4);
  localparam logic [AW-1:0] A_COMMIT = AW'(8);

  logic                    en;
  logic                    uf_mode;
  logic [7:0]              irq_thresh;
  logic                    unf;
  logic                    ovf;
  logic [SW-1:0]           stage [NUM_CHANNELS];
  logic [FW-1:0]           mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [LW-1:0]           level;
  logic                    bvalid;
  logic                    rvalid;

  logic                    wr_fire;
  logic                    rd_fire;
  logic [DW-1:0]           wmask;
  logic [NUM_CHANNELS-1:0] wr_ch_sel;
  logic [DW-1:0]           rd_word;
  logic [FW-1:0]           frame;
  logic                    wr_ctrl;
  logic                    wr_status;
  logic                    flush;
  logic                    full;
  logic                    empty;
  logic                    pop_req;
  logic                    pop_do;
  logic                    push_req;
  logic                    push_do;
  logic                    ovf_set;
  logic                    unf_set;

  // Ready is combinational so the register update lands in the handshake cycle.
  assign wr_fire       = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid & ~ARESET;
  assign rd_fire       = S_AXI_ARVALID & ~rvalid & ~ARESET;
  assign S_AXI_AWREADY = wr_fire;
  assign S_AXI_WREADY  = wr_fire;
  assign S_AXI_ARREADY = rd_fire;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RRESP   = 2'b00;

  assign wr_ctrl   = wr_fire & (S_AXI_AWADDR == A_CTRL);
  assign wr_status = wr_fire & (S_AXI_AWADDR == A_STATUS);
  assign push_req  = wr_fire & (S_AXI_AWADDR == A_COMMIT);
  assign flush     = wr_ctrl & S_AXI_WSTRB[0] & S_AXI_WDATA[1];

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign pop_req = audio_tick & en;
  assign pop_do  = pop_req & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_do = push_req & ~flush & (~full | pop_do);
  assign ovf_set = push_req & ~flush & full & ~pop_do;
  assign unf_set = pop_req & empty;

  always_comb begin
    wmask     = '0;
    wr_ch_sel = '0;
    frame     = '0;
    for (int b = 0; b < DW/8; b++) wmask[8*b +: 8] = {8{S_AXI_WSTRB[b]}};
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      wr_ch_sel[k]       = wr_fire & (S_AXI_AWADDR == AW'(16 + 4*k));
      frame[k*SW +: SW]  = stage[k];
    end
  end

  always_comb begin
    rd_word = '0;
    if (S_AXI_ARADDR == A_CTRL)
      rd_word = {16'b0, irq_thresh, 5'b0, uf_mode, 1'b0, en};
    else if (S_AXI_ARADDR == A_STATUS)
      rd_word = {12'b0, ovf, unf, full, empty, 16'(level)};
    for (int k = 0; k < NUM_CHANNELS; k++)
      if (S_AXI_ARADDR == AW'(16 + 4*k)) rd_word = DW'(stage[k]);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      bvalid      <= 1'b0;
      rvalid      <= 1'b0;
      S_AXI_RDATA <= '0;
    end else begin
      if (wr_fire)           bvalid <= 1'b1;
      else if (S_AXI_BREADY) bvalid <= 1'b0;
      if (rd_fire) begin
        rvalid      <= 1'b1;
        S_AXI_RDATA <= rd_word;
      end else if (S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      en         <= 1'b0;
      uf_mode    <= 1'b0;
      irq_thresh <= '0;
      for (int k = 0; k < NUM_CHANNELS; k++) stage[k] <= '0;
    end else begin
      if (wr_ctrl) begin
        if (S_AXI_WSTRB[0]) begin
          en      <= S_AXI_WDATA[0];
          uf_mode <= S_AXI_WDATA[2];
        end
        if (S_AXI_WSTRB[1]) irq_thresh <= S_AXI_WDATA[15:8];
      end
      for (int k = 0; k < NUM_CHANNELS; k++)
        if (wr_ch_sel[k])
          stage[k] <= SW'((DW'(stage[k]) & ~wmask) | (S_AXI_WDATA & wmask));
    end
  end

  always_ff @(posedge ACLK) begin
    if (push_do) mem[wr_ptr] <= frame;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      unf         <= 1'b0;
      ovf         <= 1'b0;
      audio_data  <= '0;
      audio_valid <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push_do) wr_ptr <= wr_ptr + PW'(1);
        if (pop_do)  rd_ptr <= rd_ptr + PW'(1);
        level <= level + LW'(push_do) - LW'(pop_do);
      end
      // Set has priority over a same-cycle write-one-to-clear.
      if (unf_set)                                       unf <= 1'b1;
      else if (wr_status & S_AXI_WSTRB[2] & S_AXI_WDATA[18]) unf <= 1'b0;
      if (ovf_set)                                       ovf <= 1'b1;
      else if (wr_status & S_AXI_WSTRB[2] & S_AXI_WDATA[19]) ovf <= 1'b0;
      audio_valid <= pop_req;
      if (pop_do)                  audio_data <= mem[rd_ptr];
      else if (unf_set && !uf_mode) audio_data <= '0;
      irq <= en & ((16'(level) <= 16'(irq_thresh)) | unf | ovf);
    end
  end

endmodule

// File: tb/tb_axi_audio_frame_bridge.sv
// Scoreboard bench for axi_audio_frame_bridge: stimulus pushes expected read data and audio
// frames into queues; negedge monitors pop and compare whenever the DUT presents them.
module tb_axi_audio_frame_bridge;

  localparam logic [5:0] A_CTRL = 6'h00, A_STATUS = 6'h04, A_COMMIT = 6'h08;
  localparam logic [5:0] A_CH0 = 6'h10, A_CH1 = 6'h14, A_CH2 = 6'h18, A_HOLE = 6'h0C;

  logic        ACLK, ARESET;
  logic [5:0]  S_AXI_AWADDR, S_AXI_ARADDR;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic        audio_tick, audio_valid, irq;
  logic [47:0] audio_data;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_rd[$];
  string       exp_rd_name[$];
  logic [47:0] exp_au[$];

  axi_audio_frame_bridge dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .audio_tick(audio_tick), .audio_data(audio_data), .audio_valid(audio_valid), .irq(irq)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  always @(negedge ACLK) begin
    if (!ARESET && S_AXI_RVALID && S_AXI_RREADY) begin
      if (exp_rd.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL rd_unexpected: got 0x%0h, required no response", S_AXI_RDATA);
      end else begin
        check({"rd_", exp_rd_name.pop_front()}, 64'(S_AXI_RDATA), 64'(exp_rd.pop_front()));
        check("rresp", 64'(S_AXI_RRESP), 64'd0);
      end
    end
    if (!ARESET && S_AXI_BVALID && S_AXI_BREADY)
      check("bresp", 64'(S_AXI_BRESP), 64'd0);
    if (!ARESET && audio_valid) begin
      if (exp_au.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL audio_unexpected: got pulse with data 0x%0h, required no pulse", audio_data);
      end else begin
        check("audio_data", 64'(audio_data), 64'(exp_au.pop_front()));
      end
    end
  end

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb = 4'hF, input bit with_tick = 1'b0);
    int n;
    @(negedge ACLK);
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; audio_tick = with_tick;
    #1;
    n = 0;
    while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 20) begin @(negedge ACLK); #1; n++; end
    if (n >= 20) timeout("aw_handshake");
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; audio_tick = 1'b0;
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin @(posedge ACLK); #1; n++; end
    if (n >= 20) timeout("bvalid_rise");
    n = 0;
    while (S_AXI_BVALID && n < 20) begin @(posedge ACLK); #1; n++; end
    if (n >= 20) timeout("bvalid_fall");
  endtask

  task automatic axi_read(input logic [5:0] addr, input logic [31:0] exp, input string name);
    int n;
    exp_rd.push_back(exp);
    exp_rd_name.push_back(name);
    @(negedge ACLK);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    #1;
    n = 0;
    while (!S_AXI_ARREADY && n < 20) begin @(negedge ACLK); #1; n++; end
    if (n >= 20) timeout("ar_handshake");
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (exp_rd.size() != 0 && n < 20) begin @(posedge ACLK); #1; n++; end
    if (n >= 20) begin
      timeout({"rvalid_", name});
      exp_rd.delete();
      exp_rd_name.delete();
    end
  endtask

  task automatic tick_once(input bit expect_pulse, input logic [47:0] exp);
    if (expect_pulse) exp_au.push_back(exp);
    @(negedge ACLK);
    audio_tick = 1'b1;
    @(posedge ACLK); #1;
    audio_tick = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
    S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1; S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1; audio_tick = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("reset_outputs",
          {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_ARREADY,
           S_AXI_RVALID, S_AXI_RRESP, audio_valid, irq}, 64'd0);
    check("reset_rdata", 64'(S_AXI_RDATA), 64'd0);
    check("reset_audio_data", 64'(audio_data), 64'd0);
    ARESET = 1'b0;

    // reset register state
    axi_read(A_CTRL,   32'h0000_0000, "ctrl_reset");
    axi_read(A_STATUS, 32'h0001_0000, "status_reset");
    axi_read(A_COMMIT, 32'h0000_0000, "commit_reset");
    axi_read(A_CH0,    32'h0000_0000, "ch0_reset");
    check("irq_reset", 64'(irq), 64'd0);

    // basic frame; upper sample bits are not stored
    axi_write(A_CH0, 32'hFF12_3456);
    axi_write(A_CH1, 32'h00AB_CDEF);
    axi_read(A_CH0, 32'h0012_3456, "ch0_trunc");
    axi_write(A_COMMIT, 32'h0);
    axi_read(A_STATUS, 32'h0000_0001, "status_one");
    axi_write(A_CTRL, 32'h1);
    tick_once(1'b1, 48'hABCDEF_123456);
    axi_read(A_STATUS, 32'h0001_0000, "status_drained");
    check("irq_level0_thresh0", 64'(irq), 64'd1);

    // byte strobes and unmapped addresses
    axi_write(A_CH1, 32'h0000_0099, 4'b0001);
    axi_read(A_CH1, 32'h00AB_CD99, "ch1_strb");
    axi_write(A_CH2, 32'hDEAD_BEEF);
    axi_write(A_HOLE, 32'hDEAD_BEEF);
    axi_read(A_CH2, 32'h0, "ch2_unmapped");
    axi_read(A_HOLE, 32'h0, "hole_unmapped");
    axi_read(A_STATUS, 32'h0001_0000, "status_after_unmapped");

    // overflow: 17 commits, the 17th is dropped
    for (int i = 0; i < 17; i++) begin
      axi_write(A_CH0, 32'(i));
      axi_write(A_COMMIT, 32'h0);
    end
    axi_read(A_STATUS, 32'h000A_0010, "status_overflow");
    axi_write(A_STATUS, 32'h0008_0000);
    axi_read(A_STATUS, 32'h0002_0010, "status_ovf_cleared");
    axi_read(A_COMMIT, 32'h0, "commit_reads_zero");

    // commit accepted at full when a tick pops in the same cycle
    exp_au.push_back(48'hABCD99_000000);
    axi_write(A_COMMIT, 32'h0, 4'hF, 1'b1);
    axi_read(A_STATUS, 32'h0002_0010, "status_full_push_pop");
    tick_once(1'b1, 48'hABCD99_000001);
    axi_read(A_STATUS, 32'h0000_000F, "status_level15");

    // flush empties the FIFO without touching audio_data
    axi_write(A_CTRL, 32'h3);
    axi_read(A_CTRL, 32'h0000_0001, "ctrl_flush_selfclear");
    axi_read(A_STATUS, 32'h0001_0000, "status_flushed");
    check("audio_after_flush", 64'(audio_data), 64'(48'hABCD99_000001));

    // underflow in both modes
    axi_write(A_CH0, 32'h2);
    axi_write(A_CH1, 32'h1);
    axi_write(A_COMMIT, 32'h0);
    tick_once(1'b1, 48'h000001_000002);
    axi_write(A_CTRL, 32'h5);
    tick_once(1'b1, 48'h000001_000002);
    axi_read(A_STATUS, 32'h0005_0000, "status_underflow");
    axi_write(A_CTRL, 32'h1);
    tick_once(1'b1, 48'h0);
    axi_read(A_STATUS, 32'h0005_0000, "status_uf_sticky");
    axi_write(A_STATUS, 32'h0004_0000);
    axi_read(A_STATUS, 32'h0001_0000, "status_uf_cleared");
    axi_write(A_CTRL, 32'h0);
    tick_once(1'b0, 48'h0);
    axi_read(A_STATUS, 32'h0001_0000, "status_tick_disabled");

    // write response back-pressure
    S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    S_AXI_AWADDR = A_CH0; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    #1 check("bp_first_aw_ready", 64'(S_AXI_AWREADY & S_AXI_WREADY), 64'd1);
    @(posedge ACLK); #1;
    S_AXI_WDATA = 32'h66;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check("bp_bvalid_held", 64'(S_AXI_BVALID), 64'd1);
      check("bp_no_second_aw", 64'({S_AXI_AWREADY, S_AXI_WREADY}), 64'd0);
    end
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    check("bp_bvalid_released", 64'(S_AXI_BVALID), 64'd0);

    // read response back-pressure
    S_AXI_RREADY = 1'b0;
    exp_rd.push_back(32'h55);
    exp_rd_name.push_back("ch0_bp");
    @(negedge ACLK);
    S_AXI_ARADDR = A_CH0; S_AXI_ARVALID = 1'b1;
    #1 check("bp_first_ar_ready", 64'(S_AXI_ARREADY), 64'd1);
    @(posedge ACLK); #1;
    S_AXI_ARADDR = A_CH1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check("bp_rvalid_held", 64'(S_AXI_RVALID), 64'd1);
      check("bp_rdata_held", 64'(S_AXI_RDATA), 64'h55);
      check("bp_no_second_ar", 64'(S_AXI_ARREADY), 64'd0);
    end
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
    for (int n = 0; n < 20 && exp_rd.size() != 0; n++) begin @(posedge ACLK); #1; end
    if (exp_rd.size() != 0) begin
      timeout("rvalid_ch0_bp");
      exp_rd.delete();
      exp_rd_name.delete();
    end

    // low-water irq: level 3 -> 2 with threshold 2
    for (int i = 0; i < 3; i++) axi_write(A_COMMIT, 32'h0);
    axi_write(A_CTRL, 32'h0000_0201, 4'b0011);
    @(negedge ACLK);
    @(negedge ACLK);
    check("irq_level3", 64'(irq), 64'd0);
    tick_once(1'b1, 48'h000001_000055);
    @(negedge ACLK);
    check("irq_same_cycle", 64'(irq), 64'd0);
    @(negedge ACLK);
    check("irq_one_later", 64'(irq), 64'd1);
    axi_read(A_STATUS, 32'h0000_0002, "status_level2");
    axi_read(A_CTRL, 32'h0000_0201, "ctrl_thresh");

    // reset with a write response pending
    S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    S_AXI_AWADDR = A_CH1; S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("midreset_bvalid_before", 64'(S_AXI_BVALID), 64'd1);
    @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("midreset_bvalid", 64'(S_AXI_BVALID), 64'd0);
    check("midreset_audio", 64'(audio_data), 64'd0);
    check("midreset_irq", 64'(irq), 64'd0);
    ARESET = 1'b0;
    S_AXI_BREADY = 1'b1;
    axi_read(A_CH1, 32'h0, "ch1_after_reset");
    axi_read(A_STATUS, 32'h0001_0000, "status_after_reset");
    axi_read(A_CTRL, 32'h0, "ctrl_after_reset");

    repeat (4) @(posedge ACLK);
    @(negedge ACLK);
    check("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
    check("audio_queue_drained", 64'(exp_au.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
